// File: rtl/seq_det_prog.sv
// Runtime-programmable serial sequence detector with per-bit don't-care mask,
// registered match pulse and saturating match counter. Optional macro SEQDET_CNT_CLEAR_EN adds count_clear.
module seq_det_prog #(
  parameter int             N               = 3,
  parameter logic [N-1:0]   SEQUENCE        = 3'b101,
  parameter int             CNT_W           = 8,
  parameter bit             OVERLAP_DEFAULT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_stream,
  input  logic             data_valid,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic [N-1:0]     cfg_mask,
  input  logic             cfg_overlap,
`ifdef SEQDET_CNT_CLEAR_EN
  input  logic             count_clear,
`endif
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int             FW        = $clog2(N + 1);
  localparam int             HW        = (N > 1) ? N - 1 : 1;
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [FW-1:0] fill_sat_inc(input logic [FW-1:0] f);
    return (f == FILL_FULL) ? FILL_FULL : f + FW'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic [N-1:0]     pattern_q, pattern_d;
  logic [N-1:0]     mask_q,    mask_d;
  logic             overlap_q, overlap_d;
  logic [HW-1:0]    hist_q,    hist_d;
  logic [FW-1:0]    fill_q,    fill_d;
  logic             out_q,     out_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             sat_q,     sat_d;

  logic             din;
  logic [N-1:0]     hist_shift;
  logic [HW-1:0]    hist_keep;
  logic [FW-1:0]    fill_shift;
  logic             hit;

  // Gating with data_valid keeps an X on an idle data_stream out of the datapath.
  assign din = data_stream & data_valid;

  // Only the N-1 youngest bits are stored: the oldest one falls out on the next shift.
  if (N == 1) begin : g_hist_1
    assign hist_shift = din;
    assign hist_keep  = 1'b0;
  end else begin : g_hist_n
    assign hist_shift = {hist_q, din};
    assign hist_keep  = hist_shift[N-2:0];
  end

  assign fill_shift = fill_sat_inc(fill_q);
  assign hit = data_valid && (fill_shift == FILL_FULL) && (|mask_q) &&
               (((hist_shift ^ pattern_q) & mask_q) == '0);

  always_comb begin
    pattern_d = pattern_q;
    mask_d    = mask_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    out_d     = 1'b0;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (data_valid) begin
      hist_d = hist_keep;
      // Non-overlapping mode restarts the window so matched bits are never reused.
      fill_d = (hit && !overlap_q) ? '0 : fill_shift;
      out_d  = hit;
      if (hit) begin
        cnt_d = cnt_sat_inc(cnt_q);
        sat_d = sat_q | (cnt_d == CNT_MAX);
      end
    end
`ifdef SEQDET_CNT_CLEAR_EN
    if (count_clear) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_q <= SEQUENCE;
      mask_q    <= '1;
      overlap_q <= OVERLAP_DEFAULT;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog: default instance (CNT_W=8)
// plus a CNT_W=2 instance sharing the same stimulus for saturation checks.
module tb_seq_det_prog;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data_stream = 1'b0;
  logic       data_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [2:0] cfg_pattern = 3'b000;
  logic [2:0] cfg_mask = 3'b000;
  logic       cfg_overlap = 1'b0;
  logic       count_clear = 1'b0;

  logic       out1, sat1;
  logic [7:0] cnt1;
  logic       out2, sat2;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_exp = 0;

  always #5 clock = ~clock;

  seq_det_prog u_dut (
    .clock(clock), .reset(reset), .data_stream(data_stream), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap),
`ifdef SEQDET_CNT_CLEAR_EN
    .count_clear(count_clear),
`endif
    .out(out1), .match_count(cnt1), .count_sat(sat1)
  );

  seq_det_prog #(.CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .data_stream(data_stream), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap),
`ifdef SEQDET_CNT_CLEAR_EN
    .count_clear(count_clear),
`endif
    .out(out2), .match_count(cnt2), .count_sat(sat2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b);
    data_valid  = 1'b1;
    data_stream = b;
    tick();
    data_valid  = 1'b0;
    data_stream = 1'bx;
  endtask

  task automatic idle();
    data_valid  = 1'b0;
    data_stream = 1'bx;
    tick();
  endtask

  task automatic cfg(input logic [2:0] p, input logic [2:0] m, input logic o,
                     input logic v, input logic b);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_mask    = m;
    cfg_overlap = o;
    data_valid  = v;
    data_stream = b;
    tick();
    cfg_load    = 1'b0;
    data_valid  = 1'b0;
    data_stream = 1'bx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] s, e_ov, e_no;
    logic [4:0]  s4;
    logic [4:0]  e4;
    int k;
    s    = 12'b110101101011;
    e_ov = 12'b000101001010;
    e_no = 12'b000100001000;

    tick(); tick();
    reset = 1'b0;
    chk("reset out", out1, 0);
    chk("reset count", cnt1, 0);
    chk("reset sat", sat1, 0);
    chk("reset count2", cnt2, 0);

    // Test 1: defaults, overlapping 101
    for (int i = 11; i >= 0; i--) begin
      send(s[i]);
      chk($sformatf("t1 out bit%0d", 12 - i), out1, e_ov[i]);
    end
    idle();
    chk("t1 out after", out1, 0);
    cnt_exp = 4;
    chk("t1 count", cnt1, cnt_exp);

    // Test 2: non-overlapping
    cfg(3'b101, 3'b111, 1'b0, 1'b0, 1'b0);
    chk("t2 cfg out", out1, 0);
    chk("t2 cfg count kept", cnt1, cnt_exp);
    for (int i = 11; i >= 0; i--) begin
      send(s[i]);
      chk($sformatf("t2 out bit%0d", 12 - i), out1, e_no[i]);
    end
    cnt_exp += 2;
    chk("t2 count", cnt1, cnt_exp);

    // Test 3: gaps with X on data_stream
    cfg(3'b101, 3'b111, 1'b1, 1'b0, 1'b0);
    send(1'b1); chk("t3 out b1", out1, 0);
    idle();     chk("t3 gap1a", out1, 0);
    idle();     chk("t3 gap1b", out1, 0);
    send(1'b0); chk("t3 out b2", out1, 0);
    idle();     chk("t3 gap2a", out1, 0);
    idle();     chk("t3 gap2b", out1, 0);
    send(1'b1); chk("t3 out b3", out1, 1);
    idle();     chk("t3 out after", out1, 0);
    cnt_exp += 1;
    chk("t3 count", cnt1, cnt_exp);

    // Test 4: masked pattern 1x0, then mask 000
    cfg(3'b100, 3'b101, 1'b1, 1'b0, 1'b0);
    s4 = 5'b11000;
    e4 = 5'b00110;
    for (int i = 4; i >= 0; i--) begin
      send(s4[i]);
      chk($sformatf("t4 out bit%0d", 5 - i), out1, e4[i]);
    end
    cnt_exp += 2;
    chk("t4 count", cnt1, cnt_exp);
    cfg(3'b101, 3'b000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(i[0] ^ i[1]);
      chk($sformatf("t4 mask0 out%0d", i), out1, 0);
    end
    chk("t4 mask0 count", cnt1, cnt_exp);

    // Test 6: reset mid-stream and cfg_load with a valid bit
    cfg(3'b101, 3'b111, 1'b1, 1'b0, 1'b0);
    send(1'b1);
    send(1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6 reset out", out1, 0);
    chk("t6 reset count", cnt1, 0);
    chk("t6 reset sat", sat1, 0);
    send(1'b1); chk("t6 post-reset b1", out1, 0);
    send(1'b0); chk("t6 post-reset b2", out1, 0);
    send(1'b1); chk("t6 post-reset b3", out1, 1);
    cnt_exp = 1;
    chk("t6 count", cnt1, cnt_exp);
    cfg(3'b101, 3'b111, 1'b1, 1'b1, 1'b1);
    chk("t6 cfg+valid out", out1, 0);
    send(1'b0); chk("t6 discard b1", out1, 0);
    send(1'b1); chk("t6 discard b2", out1, 0);
    send(1'b0); chk("t6 discard b3", out1, 0);
    send(1'b1); chk("t6 discard b4", out1, 1);
    cnt_exp += 1;
    chk("t6 count2", cnt1, cnt_exp);

`ifdef SEQDET_CNT_CLEAR_EN
    send(1'b0);
    count_clear = 1'b1;
    send(1'b1);
    count_clear = 1'b0;
    chk("clr out", out1, 1);
    chk("clr count", cnt1, 0);
    chk("clr sat2", sat2, 0);
`endif

    // Test 5: CNT_W=2 saturation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 11; i++) begin
      send((i % 2) == 0);
      if (i >= 2 && (i % 2) == 0) begin
        k++;
        chk($sformatf("t5 count2 m%0d", k), cnt2, (k > 3) ? 3 : k);
        chk($sformatf("t5 sat2 m%0d", k), sat2, (k >= 3) ? 1 : 0);
      end
    end
    chk("t5 count1", cnt1, 5);
    chk("t5 sat1", sat1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5 reset count2", cnt2, 0);
    chk("t5 reset sat2", sat2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
Parametrised, runtime-programmable serial sequence detector; successor to the fixed-pattern detector.
- Watches a 1-bit stream qualified by a valid strobe and compares the last N valid bits, MSB first, against a loadable pattern with a per-bit don't-care mask.
- Emits a registered one-cycle match pulse and keeps a saturating match counter.
- Sits at the tail of the serial-input path, feeding match events to the control/status logic.

Parameters:
N, 3, pattern length in bits (>=1)
SEQUENCE, 3'b101, pattern loaded at reset (N bits; bit N-1 = oldest bit)
CNT_W, 8, match counter width (>=1)
OVERLAP_DEFAULT, 1, overlap mode at reset (1 = overlapping, 0 = non-overlapping)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
data_stream  input  1  serial data bit; sampled only when data_valid=1
data_valid  input  1  qualifies data_stream this cycle
cfg_load  input  1  latch cfg_pattern, cfg_mask and cfg_overlap this cycle
cfg_pattern  input  N  new pattern (bit N-1 = first/oldest bit)
cfg_mask  input  N  1 = compare bit, 0 = don't care
cfg_overlap  input  1  new mode: 1 overlapping, 0 non-overlapping
out  output  1  match pulse, high for exactly one cycle
match_count  output  CNT_W  number of matches since reset, saturating
count_sat  output  1  sticky; set when match_count reaches all-ones

Behaviour:
- Reset (reset=1 at edge), all outputs and registers:
  - hist=0, fill=0, out=0, match_count=0, count_sat=0
  - pattern=SEQUENCE, mask=all-ones, overlap=OVERLAP_DEFAULT
- History and fill:
  - On each cycle with data_valid=1: hist_next={hist[N-2:0],data_stream}; fill_next=min(fill+1,N).
  - With data_valid=0: hist, fill and out-generation are frozen. data_stream is ignored, and X on it must not reach any output.
- Match condition, evaluated on the valid cycle: fill_next==N AND mask!=0 AND ((hist_next ^ pattern) & mask)==0.
  - mask==0 never matches.
- Latency: out is registered. It goes high in the cycle after the edge that sampled the final pattern bit, for one cycle only, then returns to 0 unless the next valid bit also matches.
- Overlap mode 1: history is kept after a match, so with pattern 101, the input 10101 gives 2 matches.
- Overlap mode 0: on a match, fill is cleared to 0. The next match needs N fresh valid bits, and bits of the matched window are never reused.
- cfg_load=1 (reset=0):
  - Latch pattern/mask/overlap; clear hist and fill.
  - A data_valid bit in the same cycle is discarded.
  - out is 0 next cycle; match_count and count_sat are unchanged.
- Counter:
  - match_count increments by 1 on every match (same edge that sets out).
  - At all-ones it holds and sets count_sat. count_sat clears only on reset.
- Priority: reset > cfg_load > data_valid.
- Reset asserted mid-stream discards any partial history; the first match after release needs N valid bits.

Optional Feature:
SEQDET_CNT_CLEAR_EN
- Defined: adds input count_clear (1 bit). When count_clear=1 at an edge (reset=0):
  - match_count=0 and count_sat=0.
  - A match in the same cycle still pulses out, but the count becomes 0, not 1 (clear wins).
  - History is unaffected.
- Undefined: no port. The counter clears only on reset.

Test Plan:
1. Defaults (N=3, SEQUENCE=101, overlap), data_valid=1, stream 110101101011 MSB first -> out pulses 4 times, one cycle after bits 4, 6, 9, 11; match_count=4.
2. cfg_load pattern=101, mask=111, overlap=0, same 12-bit stream -> out pulses after bits 4 and 9 only; match_count increments by 2.
3. Stream 1,0,1 with data_valid low for 2 cycles between bits and data_stream=X while invalid -> exactly one pulse, one cycle after the last valid 1; out never X.
4. cfg_pattern=100, cfg_mask=101, stream 1,1,0,0,0 -> matches on windows 110 and 100 (2 pulses); mask=000 with any stream -> no pulses.
5. CNT_W=2, 5 matches -> match_count 1,2,3,3,3; count_sat=1 after the 3rd match; reset -> both 0.
6. Stream 1,0 then reset for 1 cycle then 1 -> no match. cfg_load together with data_valid=1 -> that bit discarded, next match needs N further bits.
